// File: rtl/jtdd_snd_pkg.sv
// Shared constants and state type for the main-to-sound CPU command mailbox.
package jtdd_snd_pkg;

   localparam int IRQ_MODE_NMI = 0;
   localparam int IRQ_MODE_IRQ = 1;

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      GAP
   } nmi_state_t;

endpackage

// File: rtl/jtdd_snd_fifo.sv
// Command FIFO: register-array storage, wrap-around pointers, occupancy count and a
// registered head-of-queue output that keeps the last popped word while empty.
module jtdd_snd_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          nxt_empty,
   output logic          drop
);

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, nxt_rd;
   logic [AW:0]   nxt_count;
   logic [DW-1:0] nxt_head;
   logic          do_push, do_pop, bypass;

   always_comb begin
      do_pop    = pop & ~empty;
      do_push   = push & (~full | do_pop);
      drop      = push & full & ~do_pop;
      nxt_count = count;
      if (do_push & ~do_pop)
         nxt_count = count + CNT_ONE;
      else if (do_pop & ~do_push)
         nxt_count = count - CNT_ONE;
      nxt_rd    = do_pop ? rd_ptr + 1'b1 : rd_ptr;
      nxt_empty = (nxt_count == '0);
      // The new head is the word being written right now when nothing older remains.
      bypass    = do_push & (empty | (do_pop & (count == CNT_ONE)));
      nxt_head  = bypass ? din : mem[nxt_rd];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         dout   <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= nxt_rd;
         count  <= nxt_count;
         full   <= (nxt_count == CNT_FULL);
         empty  <= nxt_empty;
         if (!nxt_empty)
            dout <= nxt_head;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/jtdd_snd_mailbox.sv
// Main-to-sound CPU command mailbox: FIFO, access-end pop, sticky overflow and NMI/IRQ
// generation. Define JTDD_SND_REPLY_EN to add the sound-to-main reply register.
module jtdd_snd_mailbox
   import jtdd_snd_pkg::*;
#(
   parameter int DW       = 8,
   parameter int DEPTH    = 4,
   parameter int AW       = $clog2(DEPTH),
   parameter int IRQ_MODE = IRQ_MODE_NMI,
   parameter int NMI_GAP  = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          main_wr,
   input  logic [DW-1:0] main_din,
   output logic          main_full,
   input  logic          snd_cs,
   output logic [DW-1:0] snd_dout,
   output logic          snd_empty,
   output logic          snd_ovf,
   input  logic          ovf_clr,
   output logic [AW:0]   count,
   output logic          nmi_n,
   output logic          irq_n
`ifdef JTDD_SND_REPLY_EN
   ,
   input  logic          rep_wr,
   input  logic [DW-1:0] rep_din,
   output logic [DW-1:0] main_rep,
   output logic          main_rep_rdy,
   input  logic          main_rep_ack
`endif
);

   localparam int          GW       = $clog2(NMI_GAP + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(NMI_GAP - 1);

   logic          cs_d, cs_rise, cs_fall;
   logic          fifo_drop, nxt_empty, irq_q;
   nmi_state_t    state, nxt_state;
   logic [GW-1:0] gap_cnt, nxt_gap;

   assign cs_rise = snd_cs & ~cs_d;
   assign cs_fall = cs_d & ~snd_cs;

   jtdd_snd_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (main_wr),
      .din       (main_din),
      .pop       (cs_fall),
      .dout      (snd_dout),
      .count     (count),
      .full      (main_full),
      .empty     (snd_empty),
      .nxt_empty (nxt_empty),
      .drop      (fifo_drop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_d    <= 1'b0;
         snd_ovf <= 1'b0;
         irq_q   <= 1'b1;
         state   <= IDLE;
         gap_cnt <= '0;
      end else begin
         cs_d <= snd_cs;
         if (fifo_drop)
            snd_ovf <= 1'b1;
         else if (ovf_clr)
            snd_ovf <= 1'b0;
         irq_q   <= nxt_empty;
         state   <= nxt_state;
         gap_cnt <= nxt_gap;
      end
   end

   // The handler entry (chip-select rising) acknowledges the pulse; the gap lets the
   // sound CPU finish before it is interrupted again.
   always_comb begin
      nxt_state = state;
      nxt_gap   = gap_cnt;
      case (state)
         IDLE: begin
            if (!snd_empty)
               nxt_state = ASSERT;
         end
         ASSERT: begin
            if (cs_rise) begin
               nxt_state = GAP;
               nxt_gap   = '0;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST)
               nxt_state = nxt_empty ? IDLE : ASSERT;
            else
               nxt_gap = gap_cnt + 1'b1;
         end
         default: nxt_state = IDLE;
      endcase
   end

   assign nmi_n = (IRQ_MODE == IRQ_MODE_NMI) ? (state != ASSERT) : 1'b1;
   assign irq_n = (IRQ_MODE == IRQ_MODE_IRQ) ? irq_q : 1'b1;

`ifdef JTDD_SND_REPLY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_rep     <= '0;
         main_rep_rdy <= 1'b0;
      end else if (rep_wr) begin
         main_rep     <= rep_din;
         main_rep_rdy <= 1'b1;
      end else if (main_rep_ack) begin
         main_rep_rdy <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_jtdd_snd_mailbox.sv
// Bench for jtdd_snd_mailbox: an NMI-mode and an IRQ-mode instance share one stimulus
// stream and are checked every cycle against a queue-based model plus literal checkpoints.
module tb_jtdd_snd_mailbox;

   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int NMI_GAP = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         main_wr = 1'b0;
   logic [7:0]   main_din = '0;
   logic         snd_cs = 1'b0;
   logic         ovf_clr = 1'b0;

   logic         full0, empty0, ovf0, nmi0, irq0;
   logic         full1, empty1, ovf1, nmi1, irq1;
   logic [7:0]   dout0, dout1;
   logic [2:0]   count0, count1;

`ifdef JTDD_SND_REPLY_EN
   logic         rep_wr = 1'b0;
   logic [7:0]   rep_din = '0;
   logic         main_rep_ack = 1'b0;
   logic [7:0]   main_rep0, main_rep1;
   logic         rdy0, rdy1;
`endif

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   jtdd_snd_mailbox #(.DW(DW), .DEPTH(DEPTH), .IRQ_MODE(0), .NMI_GAP(NMI_GAP)) u_nmi (
      .clk(clk), .rst_n(rst_n), .main_wr(main_wr), .main_din(main_din),
      .main_full(full0), .snd_cs(snd_cs), .snd_dout(dout0), .snd_empty(empty0),
      .snd_ovf(ovf0), .ovf_clr(ovf_clr), .count(count0), .nmi_n(nmi0), .irq_n(irq0)
`ifdef JTDD_SND_REPLY_EN
      , .rep_wr(rep_wr), .rep_din(rep_din), .main_rep(main_rep0),
      .main_rep_rdy(rdy0), .main_rep_ack(main_rep_ack)
`endif
   );

   jtdd_snd_mailbox #(.DW(DW), .DEPTH(DEPTH), .IRQ_MODE(1), .NMI_GAP(NMI_GAP)) u_irq (
      .clk(clk), .rst_n(rst_n), .main_wr(main_wr), .main_din(main_din),
      .main_full(full1), .snd_cs(snd_cs), .snd_dout(dout1), .snd_empty(empty1),
      .snd_ovf(ovf1), .ovf_clr(ovf_clr), .count(count1), .nmi_n(nmi1), .irq_n(irq1)
`ifdef JTDD_SND_REPLY_EN
      , .rep_wr(rep_wr), .rep_din(rep_din), .main_rep(main_rep1),
      .main_rep_rdy(rdy1), .main_rep_ack(main_rep_ack)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of pending commands plus interrupt bookkeeping.
   logic [7:0] q[$];
   logic [7:0] m_dout;
   bit         m_ovf, m_csd, m_nmi_low;
   int         m_gap_left;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_dout = '0; m_ovf = 0; m_csd = 0; m_nmi_low = 0; m_gap_left = 0;
      end else begin
         int  pre;
         bit  fall, rise, popped, dropped;
         pre     = q.size();
         fall    = m_csd && !snd_cs;
         rise    = !m_csd && snd_cs;
         popped  = fall && pre > 0;
         dropped = 0;
         if (popped) void'(q.pop_front());
         if (main_wr) begin
            if (pre < DEPTH || popped) q.push_back(main_din);
            else dropped = 1;
         end
         if (dropped) m_ovf = 1;
         else if (ovf_clr) m_ovf = 0;
         if (q.size() > 0) m_dout = q[0];
         if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0) m_nmi_low = (q.size() > 0);
         end else if (m_nmi_low) begin
            if (rise) begin m_nmi_low = 0; m_gap_left = NMI_GAP; end
         end else if (pre > 0) begin
            m_nmi_low = 1;
         end
         m_csd = snd_cs;
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("dout0", dout0, m_dout);
         check("count0", count0, q.size());
         check("full0", full0, q.size() == DEPTH);
         check("empty0", empty0, q.size() == 0);
         check("ovf0", ovf0, m_ovf);
         check("nmi0", nmi0, !m_nmi_low);
         check("irq0", irq0, 1);
         check("dout1", dout1, m_dout);
         check("count1", count1, q.size());
         check("ovf1", ovf1, m_ovf);
         check("irq1", irq1, q.size() == 0);
         check("nmi1", nmi1, 1);
      end
   end

   task automatic cyc(input bit wr, input logic [7:0] d, input bit cs, input bit clr);
      main_wr = wr; main_din = d; snd_cs = cs; ovf_clr = clr;
      @(negedge clk);
      main_wr = 0; ovf_clr = 0;
   endtask

   task automatic pop_one();
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      check("rst_count", count0, 0);
      check("rst_empty", empty0, 1);
      check("rst_full", full0, 0);
      check("rst_ovf", ovf0, 0);
      check("rst_dout", dout0, 0);
      check("rst_nmi", nmi0, 1);
      check("rst_irq", irq1, 1);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      // two commands, then one full sound-CPU access
      cyc(1, 8'h12, 0, 0);
      cyc(1, 8'h34, 0, 0);
      check("t1_count", count0, 2);
      check("t1_dout", dout0, 8'h12);
      check("t1_nmi", nmi0, 0);
      repeat (4) cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);
      check("t1_dout_pop", dout0, 8'h34);
      check("t1_count_pop", count0, 1);

      // wait out the gap, then measure the next one exactly
      n = 0;
      while (nmi0 && n < 40) begin cyc(0, 8'h00, 0, 0); n++; end
      check("nmi_reassert", nmi0, 0);
      cyc(1, 8'h56, 0, 0);
      cyc(0, 8'h00, 1, 0);
      n = nmi0 ? 1 : 0;
      while (nmi0 && n < 40) begin
         cyc(0, 8'h00, 1, 0);
         if (nmi0) n++;
      end
      check("gap_len", n, NMI_GAP);
      cyc(0, 8'h00, 0, 0);
      check("gap_pop_count", count0, 1);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);
      repeat (20) cyc(0, 8'h00, 0, 0);
      check("idle_nmi", nmi0, 1);
      check("idle_empty", empty0, 1);

      // level IRQ instance
      cyc(1, 8'h55, 0, 0);
      check("irq_low", irq1, 0);
      check("irq_dout", dout1, 8'h55);
      pop_one();
      check("irq_high", irq1, 1);

      // overflow; set wins over a simultaneous clear
      cyc(1, 8'hA0, 0, 0);
      cyc(1, 8'hA1, 0, 0);
      cyc(1, 8'hA2, 0, 0);
      cyc(1, 8'hA3, 0, 0);
      cyc(1, 8'hA4, 0, 1);
      check("ovf_full", full0, 1);
      check("ovf_set", ovf0, 1);
      check("ovf_count", count0, 4);
      check("ovf_head", dout0, 8'hA0);
      cyc(0, 8'h00, 0, 1);
      check("ovf_clr", ovf0, 0);

      // push on the same cycle as the pop of a full FIFO
      cyc(0, 8'h00, 1, 0);
      cyc(1, 8'hB5, 0, 0);
      check("pp_count", count0, 4);
      check("pp_ovf", ovf0, 0);
      check("pp_head", dout0, 8'hA1);
      pop_one(); check("drain_a2", dout0, 8'hA2);
      pop_one(); check("drain_a3", dout0, 8'hA3);
      pop_one(); check("drain_b5", dout0, 8'hB5);
      pop_one(); check("drain_hold", dout0, 8'hB5);
      check("drain_empty", empty0, 1);
      pop_one(); check("empty_pop", count0, 0);

      // asynchronous reset in the middle of traffic
      cyc(1, 8'hC0, 0, 0);
      cyc(1, 8'hC1, 0, 0);
      cyc(1, 8'hC2, 0, 0);
      cyc(1, 8'hC3, 0, 0);
      cyc(1, 8'hC4, 0, 0);
      pop_one();
      check("pre_rst_count", count0, 3);
      check("pre_rst_ovf", ovf0, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", count0, 0);
      check("arst_empty", empty0, 1);
      check("arst_nmi", nmi0, 1);
      check("arst_ovf", ovf0, 0);
      check("arst_dout", dout0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef JTDD_SND_REPLY_EN
      check("rep_rst", rdy0, 0);
      rep_wr = 1; rep_din = 8'h7E;
      @(negedge clk);
      rep_wr = 0;
      check("rep_val", main_rep0, 8'h7E);
      check("rep_rdy", rdy0, 1);
      main_rep_ack = 1;
      @(negedge clk);
      main_rep_ack = 0;
      check("rep_ack", rdy0, 0);
      rep_wr = 1; rep_din = 8'h81; main_rep_ack = 1;
      @(negedge clk);
      rep_wr = 0; main_rep_ack = 0;
      check("rep_both_rdy", rdy0, 1);
      check("rep_both_val", main_rep0, 8'h81);
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
